// File: rtl/uart_bus_slave_pkg.sv
// uart_bus_slave_pkg: shared constants and types for the UART bus slave.
//   Bus widths, register offsets (address bits [3:2]), STATUS/CTRL bit
//   indices, the code returned when reading an empty RX FIFO, FSM state
//   types and the mid-bit reload helper used by the RX start-bit check.
package uart_bus_slave_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_EMPTY  = 2;
    localparam int ST_RX_FULL   = 3;
    localparam int ST_TX_OVF    = 4;
    localparam int ST_RX_OVR    = 5;
    localparam int ST_FRAME_ERR = 6;
    localparam int ST_TX_BUSY   = 7;

    localparam int CTRL_RX_IE    = 0;
    localparam int CTRL_TX_IE    = 1;
    localparam int CTRL_LOOPBACK = 2;

    localparam logic [WORD_W-1:0] RX_EMPTY_CODE = 32'h8000_0000;

    typedef enum logic {BUS_IDLE, BUS_RESP} bus_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Counter reload after the falling edge so that the start-bit re-check
    // lands near the middle of the bit: sample offset = (div+1)/2 cycles.
    function automatic logic [15:0] mid_load(input logic [15:0] div);
        logic [16:0] bit_len;
        bit_len = {1'b0, div} + 17'd1;
        return (bit_len[16:1] == 16'd0) ? 16'd0 : bit_len[16:1] - 16'd1;
    endfunction

endpackage

// File: rtl/uart_bus_slave_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational read of the head entry.
//   clk, rst_n       clock, async active-low reset
//   push, din        write request / data (ignored when full unless popping)
//   pop, dout        read request (ignored when empty) / head data
//   full, empty      status flags
//   count            current number of entries
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO succeeds when a pop frees the slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_bus_slave.sv
// uart_bus_slave: memory-mapped 8N1 UART with TX/RX FIFOs and level irq.
//   clk, rst_n           clock, async active-low reset
//   s_valid_i/s_ready_o  bus request / one-cycle response strobe
//   s_addr_i             byte address, [3:2] selects DATA/STATUS/CTRL/BAUD
//   s_wdata_i, s_we_i    write data, byte strobes (0 = read)
//   s_rdata_o            read data, held outside the response cycle
//   tx_o, rx_i           serial out (idle high), serial in (async)
//   irq_o                registered level interrupt
// Optional feature: define UART_LOOPBACK_EN to build the CTRL[2] loopback
// path (TX bit into RX synchronizer, tx_o held high while set).
module uart_bus_slave
    import uart_bus_slave_pkg::*;
#(
    parameter int          TX_DEPTH     = 8,
    parameter int          RX_DEPTH     = 8,
    parameter logic [15:0] BAUD_DIV_RST = 16'd867
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [ADDR_W-1:0] s_addr_i,
    input  logic [WORD_W-1:0] s_wdata_i,
    input  logic [3:0]        s_we_i,
    output logic [WORD_W-1:0] s_rdata_o,
    output logic              tx_o,
    input  logic              rx_i,
    output logic              irq_o
);
    bus_state_t bus_state;
    tx_state_t  tx_state;
    rx_state_t  rx_state;

    logic [15:0] baud_div;
    logic        rx_ie, tx_ie, loopback;
    logic        tx_ovf, rx_ovr, frame_err;

    logic tx_push, tx_pop, tx_full, tx_empty;
    logic rx_push, rx_pop, rx_full, rx_empty, rx_ferr;
    logic [7:0] tx_dout, rx_dout;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic [$clog2(RX_DEPTH):0] rx_count;

    logic [15:0] tx_cnt, rx_cnt;
    logic [2:0]  tx_idx, rx_idx;
    logic [7:0]  tx_shift, rx_shift;
    logic        tx_line, rx_in, rx_s1, rx_s2, rx_prev;

    logic              accept, is_write;
    logic [1:0]        reg_sel;
    logic [7:0]        status;
    logic [WORD_W-1:0] rd_val;
    logic              unused_bits;

    assign unused_bits = ^{s_addr_i[ADDR_W-1:4], s_addr_i[1:0],
                           s_wdata_i[WORD_W-1:16], tx_count, rx_count};

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .din(s_wdata_i[7:0]),
        .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_shift),
        .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    // ---------------- bus side ----------------
    assign accept   = (bus_state == BUS_IDLE) && s_valid_i;
    assign reg_sel  = s_addr_i[3:2];
    assign is_write = |s_we_i;
    assign tx_push  = accept && (reg_sel == REG_DATA) && s_we_i[0];
    assign rx_pop   = accept && (reg_sel == REG_DATA) && !is_write && !rx_empty;

    always_comb begin
        status               = '0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_RX_EMPTY]  = rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_OVF]    = tx_ovf;
        status[ST_RX_OVR]    = rx_ovr;
        status[ST_FRAME_ERR] = frame_err;
        status[ST_TX_BUSY]   = (tx_state != TX_IDLE);
    end

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_DATA:   rd_val = rx_empty ? RX_EMPTY_CODE : {24'h0, rx_dout};
            REG_STATUS: rd_val = {24'h0, status};
            REG_CTRL:   rd_val = {29'h0, loopback, tx_ie, rx_ie};
            REG_BAUD:   rd_val = {16'h0, baud_div};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_state <= BUS_IDLE;
            s_ready_o <= 1'b0;
            s_rdata_o <= '0;
        end else begin
            case (bus_state)
                BUS_IDLE: if (s_valid_i) begin
                    bus_state <= BUS_RESP;
                    s_ready_o <= 1'b1;
                    if (!is_write) s_rdata_o <= rd_val;
                end
                BUS_RESP: begin
                    bus_state <= BUS_IDLE;
                    s_ready_o <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_LOOPBACK_EN
    assign loopback = 1'b0;
`endif

    // Register writes and sticky flags; a set in the same cycle as a
    // write-1-clear wins so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div  <= BAUD_DIV_RST;
            rx_ie     <= 1'b0;
            tx_ie     <= 1'b0;
`ifdef UART_LOOPBACK_EN
            loopback  <= 1'b0;
`endif
            tx_ovf    <= 1'b0;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (accept && s_we_i[0] && reg_sel == REG_CTRL) begin
                rx_ie    <= s_wdata_i[CTRL_RX_IE];
                tx_ie    <= s_wdata_i[CTRL_TX_IE];
`ifdef UART_LOOPBACK_EN
                loopback <= s_wdata_i[CTRL_LOOPBACK];
`endif
            end
            if (accept && reg_sel == REG_BAUD) begin
                if (s_we_i[0]) baud_div[7:0]  <= s_wdata_i[7:0];
                if (s_we_i[1]) baud_div[15:8] <= s_wdata_i[15:8];
            end
            if (accept && s_we_i[0] && reg_sel == REG_STATUS) begin
                if (s_wdata_i[ST_TX_OVF])    tx_ovf    <= 1'b0;
                if (s_wdata_i[ST_RX_OVR])    rx_ovr    <= 1'b0;
                if (s_wdata_i[ST_FRAME_ERR]) frame_err <= 1'b0;
            end
            if (tx_push && tx_full && !tx_pop) tx_ovf    <= 1'b1;
            if (rx_push && rx_full && !rx_pop) rx_ovr    <= 1'b1;
            if (rx_ferr)                       frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_o <= 1'b0;
        else        irq_o <= (rx_ie && !rx_empty) || (tx_ie && tx_empty);
    end

    // ---------------- transmitter ----------------
    assign tx_pop = (tx_state == TX_IDLE) && !tx_empty;
    assign tx_o   = tx_line | loopback;

    // baud_div is read only at reloads, so divider writes apply from the
    // next bit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_line  <= 1'b1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: if (!tx_empty) begin
                    tx_shift <= tx_dout;
                    tx_line  <= 1'b0;
                    tx_cnt   <= baud_div;
                    tx_state <= TX_START;
                end
                TX_START: if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
                else begin
                    tx_cnt   <= baud_div;
                    tx_line  <= tx_shift[0];
                    tx_idx   <= '0;
                    tx_state <= TX_DATA;
                end
                TX_DATA: if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
                else begin
                    tx_cnt <= baud_div;
                    if (tx_idx == 3'd7) begin
                        tx_line  <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_idx   <= tx_idx + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_line  <= tx_shift[1];
                    end
                end
                TX_STOP: if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
                else tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_line : rx_i;
`else
    assign rx_in = rx_i;
`endif

    assign rx_push = (rx_state == RX_STOP) && (rx_cnt == '0) && rx_s2;
    assign rx_ferr = (rx_state == RX_STOP) && (rx_cnt == '0) && !rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1   <= rx_in;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s2) begin
                    rx_cnt   <= mid_load(baud_div);
                    rx_state <= RX_START;
                end
                RX_START: if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
                else if (rx_s2) rx_state <= RX_IDLE;   // glitch, not a start bit
                else begin
                    rx_cnt   <= baud_div;
                    rx_idx   <= '0;
                    rx_state <= RX_DATA;
                end
                RX_DATA: if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
                else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_cnt   <= baud_div;
                    rx_idx   <= rx_idx + 3'd1;
                    if (rx_idx == 3'd7) rx_state <= RX_STOP;
                end
                RX_STOP: if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
                else rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule
